// File: rtl/div5_rr_sched.sv
// Round-robin arbiter in front of one bit-serial mod-DIV remainder engine; returns id, remainder and divisible flag.
// Accept to rsp_valid is WIDTH+1 cycles; the result is held in RESP until rsp_ready, and no new grant is made until then.
module div5_rr_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DIV   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_div,
  output logic [$clog2(DIV)-1:0]   rsp_rem,
  output logic                     busy
);

  localparam int RW  = $clog2(DIV);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_div_q, rsp_div_d;
  logic             busy_q, busy_d;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   idx_v;
  int               idx;
  logic [RW:0]      t;

  // Search starts one past the last served requester so the previous winner has lowest priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    idx_v     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_v = IDW'(idx);
      if (!gnt_found && req_valid[idx_v]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx_v;
      end
    end
  end

  assign req_ready = (state_q == IDLE && gnt_found && !rst) ? (NREQ'(1) << gnt_idx) : '0;

  // 2*rem + bit stays below 2*DIV, so one conditional subtract keeps the remainder reduced.
  assign t = {rem_q, sreg_q[WIDTH-1]};

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    sreg_d      = sreg_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_div_d   = rsp_div_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          sreg_d  = req_data[gnt_idx*WIDTH +: WIDTH];
          rem_d   = '0;
          cnt_d   = '0;
          id_d    = gnt_idx;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        rem_d  = (t >= (RW+1)'(DIV)) ? RW'(t - (RW+1)'(DIV)) : RW'(t);
        sreg_d = sreg_q << 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_div_d   = (rem_d == '0);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rr_ptr_d    = id_q;
          rsp_valid_d = 1'b0;
          rsp_div_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IDW'(NREQ-1);
      id_q        <= '0;
      sreg_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_div_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      sreg_q      <= sreg_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_div_q   <= rsp_div_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_rem   = rem_q;
  assign rsp_div   = rsp_div_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_div5_rr_sched.sv
// Directed bench for div5_rr_sched: single words, round-robin order, response stall and mid-shift reset.
module tb_div5_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic        rsp_div;
  logic [2:0]  rsp_rem;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div5_rr_sched #(.NREQ(4), .WIDTH(8), .DIV(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_div   (rsp_div),
    .rsp_rem   (rsp_rem),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [7:0] w);
    req_data[i*8 +: 8] = w;
  endtask

  // Called at a negedge in IDLE with the request already driven; returns at the negedge after the handshake.
  task automatic serve(input logic [3:0] exp_rdy, input int exp_id, input int exp_rem, input bit drop);
    int lat;
    chk("req_ready_grant", req_ready, exp_rdy);
    chk("busy_idle", busy, 0);
    @(posedge clk);
    #1;
    if (drop) begin
      req_valid = 4'b0000;
      req_data  = $urandom;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("busy_shift", busy, 1);
      if (!rsp_valid) chk("req_ready_busy", req_ready, 0);
    end while (!rsp_valid && lat < 30);
    chk("latency", lat, 9);
    chk("rsp_id", rsp_id, exp_id);
    chk("rsp_rem", rsp_rem, exp_rem);
    chk("rsp_div", rsp_div, (exp_rem == 0));
    @(negedge clk);
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("busy_back_idle", busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    bit seen;
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_rem", rsp_rem, 0);
    chk("rst_rsp_div", rsp_div, 0);
    req_valid = 4'b0000;
    rst = 1'b0;
    @(negedge clk);

    // Single word 10 from requester 0: divisible.
    req_valid = 4'b0001; set_word(0, 8'd10); #1;
    serve(4'b0001, 0, 0, 1'b1);

    // Single words from different requesters.
    req_valid = 4'b0010; set_word(1, 8'd13); #1;
    serve(4'b0010, 1, 3, 1'b1);
    req_valid = 4'b0100; set_word(2, 8'd0); #1;
    serve(4'b0100, 2, 0, 1'b1);
    req_valid = 4'b1000; set_word(3, 8'd255); #1;
    serve(4'b1000, 3, 0, 1'b1);
    req_valid = 4'b0001; set_word(0, 8'd254); #1;
    serve(4'b0001, 0, 4, 1'b1);

    // All requesting, held: rotation 0,1,2,3,0.
    do_reset();
    set_word(0, 8'd13); set_word(1, 8'd0); set_word(2, 8'd254); set_word(3, 8'd7);
    req_valid = 4'b1111; #1;
    serve(4'b0001, 0, 3, 1'b0);
    serve(4'b0010, 1, 0, 1'b0);
    serve(4'b0100, 2, 4, 1'b0);
    serve(4'b1000, 3, 2, 1'b0);
    serve(4'b0001, 0, 3, 1'b0);
    req_valid = 4'b0000;
    @(negedge clk);
    chk("withdraw_busy", busy, 0);

    // Sparse requesters 1 and 3: rotation 1,3,1,3.
    do_reset();
    req_valid = 4'b1010; #1;
    serve(4'b0010, 1, 0, 1'b0);
    serve(4'b1000, 3, 2, 1'b0);
    serve(4'b0010, 1, 0, 1'b0);
    serve(4'b1000, 3, 2, 1'b0);

    // Response stall: outputs held, other requesters ignored.
    req_valid = 4'b0100; set_word(2, 8'd13); rsp_ready = 1'b0; #1;
    chk("stall_grant", req_ready, 4'b0100);
    @(posedge clk);
    #1;
    req_valid = 4'b1011;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 30);
    chk("stall_latency", lat, 9);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_id", rsp_id, 2);
      chk("stall_rsp_rem", rsp_rem, 3);
      chk("stall_rsp_div", rsp_div, 0);
      chk("stall_req_ready", req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_rsp_valid_drop", rsp_valid, 0);
    chk("stall_busy", busy, 0);
    chk("stall_next_grant", req_ready, 4'b1000);
    req_valid = 4'b0000;

    // Reset in the 4th shift cycle aborts the operation and restores the pointer.
    req_valid = 4'b0010; set_word(1, 8'd13); #1;
    chk("abort_grant", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    repeat (4) @(negedge clk);
    chk("abort_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("abort_no_rsp", seen, 0);
    chk("abort_busy_after", busy, 0);
    req_valid = 4'b1111; #1;
    chk("abort_regrant", req_ready, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
